// File: rtl/elevator_ctrl.sv
// Elevator floor scheduler: latches calls, picks direction with a SCAN policy,
// steps one floor per TRAVEL_TICKS timebase ticks and holds the door DOOR_TICKS ticks.
module elevator_ctrl #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = 2,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  state_t                state, state_n;
  dir_t                  dir, dir_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [FLOOR_W-1:0]    floor_n, nf;
  logic [NUM_FLOORS-1:0] pending_n, eff, set, clr;
  logic                  restart, travel_done;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] calls,
                                     input logic [FLOOR_W-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (i > 32'(f) && calls[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] calls,
                                     input logic [FLOOR_W-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (i < 32'(f) && calls[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] bit_of(input logic [FLOOR_W-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

  always_comb begin
    state_n     = state;
    dir_n       = dir;
    floor_n     = cur_floor;
    nf          = cur_floor;
    clr         = '0;
    restart     = 1'b0;
    // Calls arriving on the arrival clk count as already pending there.
    eff         = pending | req;
    set         = req;
    if (state == DOOR) set[cur_floor] = 1'b0;
    travel_done = tick && (cnt == CNT_W'(TRAVEL_TICKS - 1));

    case (state)
      IDLE: begin
        if (pending[cur_floor]) begin
          state_n = DOOR;
          clr     = bit_of(cur_floor);
        end else if (any_above(pending, cur_floor) &&
                     (dir == DIR_UP || !any_below(pending, cur_floor))) begin
          state_n = MOVE_UP;
          dir_n   = DIR_UP;
        end else if (any_below(pending, cur_floor)) begin
          state_n = MOVE_DOWN;
          dir_n   = DIR_DOWN;
        end
      end
      MOVE_UP: begin
        if (travel_done) begin
          nf      = cur_floor + FLOOR_W'(1);
          floor_n = nf;
          if (eff[nf]) begin
            state_n = DOOR;
            clr     = bit_of(nf);
          end else if (any_above(eff, nf)) begin
            restart = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      MOVE_DOWN: begin
        if (travel_done) begin
          nf      = cur_floor - FLOOR_W'(1);
          floor_n = nf;
          if (eff[nf]) begin
            state_n = DOOR;
            clr     = bit_of(nf);
          end else if (any_below(eff, nf)) begin
            restart = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DOOR: begin
        if (req[cur_floor]) restart = 1'b1;
        else if (tick && cnt == CNT_W'(DOOR_TICKS - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // A tick on a transition clk is dropped, as is one on a restart clk.
    if (state_n != state || restart) cnt_n = '0;
    else if (tick)                   cnt_n = cnt + CNT_W'(1);
    else                             cnt_n = cnt;

    pending_n = (pending | set) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dir         <= DIR_UP;
      cnt         <= '0;
      cur_floor   <= '0;
      pending     <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      state       <= state_n;
      dir         <= dir_n;
      cnt         <= cnt_n;
      cur_floor   <= floor_n;
      pending     <= pending_n;
      moving_up   <= (state_n == MOVE_UP);
      moving_down <= (state_n == MOVE_DOWN);
      door_open   <= (state_n == DOOR);
    end
  end

endmodule
